// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; data wins ties, reads take MEM_LAT+1 cycles, writes take 2 cycles.
// Optional fetch-starvation guard enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_ACK,
  output logic [31:0] IF_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [2:0]  D_SIZE,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [2:0]  MEM_SIZE,
  output logic        MEM_RE,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RDATA,
  output logic        STALL_IF,
  output logic        STALL_D
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic        own_d, own_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_size;
  logic [2:0]  cnt;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        grant_d, grant_if;
  logic        fetch_turn;

`ifdef ARB_FAIRNESS_EN
  localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);
  logic [2:0] streak;

  assign fetch_turn = (streak == STREAK_MAX) && IF_REQ && D_REQ;

  // Only data grants that overtook a waiting fetch count toward the streak.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      streak <= 3'd0;
    end else if (state == IDLE) begin
      if (!IF_REQ || grant_if) streak <= 3'd0;
      else if (grant_d)        streak <= streak + 3'd1;
    end
  end
`else
  logic unused_streak_cfg;
  assign unused_streak_cfg = ^3'(MAX_DATA_STREAK);
  assign fetch_turn        = 1'b0;
`endif

  assign grant_d  = (state == IDLE) && D_REQ && !fetch_turn;
  assign grant_if = (state == IDLE) && IF_REQ && !grant_d;

  always_comb begin
    state_nxt = state;
    MEM_ADDR  = lat_addr;
    MEM_WDATA = lat_wdata;
    MEM_SIZE  = lat_size;
    MEM_RE    = 1'b0;
    MEM_WE    = 1'b0;
    IF_ACK    = 1'b0;
    D_ACK     = 1'b0;
    IF_RDATA  = if_rdata_q;
    D_RDATA   = d_rdata_q;
    case (state)
      IDLE: begin
        if (grant_d) begin
          MEM_ADDR  = D_ADDR;
          MEM_WDATA = D_WDATA;
          MEM_SIZE  = D_SIZE;
          MEM_WE    = D_WE;
          MEM_RE    = !D_WE;
          state_nxt = (D_WE || MEM_LAT == 1) ? RESP : WAIT;
        end else if (grant_if) begin
          MEM_ADDR  = IF_ADDR;
          MEM_SIZE  = 3'b010;
          MEM_RE    = 1'b1;
          state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) state_nxt = RESP;
      end
      RESP: begin
        // Bypass read data so the owner sees it in the ACK cycle itself.
        if (own_d) begin
          D_ACK = 1'b1;
          if (!own_we) D_RDATA = MEM_RDATA;
        end else begin
          IF_ACK   = 1'b1;
          IF_RDATA = MEM_RDATA;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      own_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_size   <= 3'd0;
      cnt        <= 3'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_d || grant_if) begin
        own_d     <= grant_d;
        own_we    <= grant_d && D_WE;
        lat_addr  <= MEM_ADDR;
        lat_wdata <= MEM_WDATA;
        lat_size  <= MEM_SIZE;
        cnt       <= LAT_M1;
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
      end
      if (state == RESP && !own_we) begin
        if (own_d) d_rdata_q  <= MEM_RDATA;
        else       if_rdata_q <= MEM_RDATA;
      end
    end
  end

  assign STALL_IF = IF_REQ && !IF_ACK;
  assign STALL_D  = D_REQ && !D_ACK;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3, each with its own memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        if_ack    [3];
  logic [31:0] if_rdata  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic [2:0]  d_size    [3];
  logic        d_ack     [3];
  logic [31:0] d_rdata   [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [2:0]  mem_size  [3];
  logic        mem_re    [3];
  logic        mem_we    [3];
  logic [31:0] mem_rdata [3];
  logic        stall_if  [3];
  logic        stall_d   [3];

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    ref_word = (a == 32'h100) ? 32'h0050_0093 : (32'hA500_0000 | a);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem  [4096];
    logic [31:0] pipe [7];

    mem_port_arbiter #(.MEM_LAT(g + 1), .MAX_DATA_STREAK(4)) u_dut (
      .CLOCK(clk), .RESET(rst),
      .IF_REQ(if_req[g]), .IF_ADDR(if_addr[g]), .IF_ACK(if_ack[g]), .IF_RDATA(if_rdata[g]),
      .D_REQ(d_req[g]), .D_WE(d_we[g]), .D_ADDR(d_addr[g]), .D_WDATA(d_wdata[g]),
      .D_SIZE(d_size[g]), .D_ACK(d_ack[g]), .D_RDATA(d_rdata[g]),
      .MEM_ADDR(mem_addr[g]), .MEM_WDATA(mem_wdata[g]), .MEM_SIZE(mem_size[g]),
      .MEM_RE(mem_re[g]), .MEM_WE(mem_we[g]), .MEM_RDATA(mem_rdata[g]),
      .STALL_IF(stall_if[g]), .STALL_D(stall_d[g])
    );

    initial begin
      for (int i = 0; i < 4096; i++) mem[i] = ref_word(32'(i) << 2);
      for (int j = 0; j < 7; j++) pipe[j] = 32'hBAD0_0BAD;
    end

    // Read data appears exactly MEM_LAT cycles after the strobe; garbage otherwise.
    always @(posedge clk) begin
      if (mem_we[g]) mem[mem_addr[g][13:2]] <= mem_wdata[g];
      pipe[0] <= mem_re[g] ? mem[mem_addr[g][13:2]] : 32'hBAD0_0BAD;
      for (int j = 1; j < 7; j++) pipe[j] <= pipe[j-1];
    end

    assign mem_rdata[g] = pipe[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if ((mem_re[k] && mem_we[k]) || (if_ack[k] && d_ack[k])) viol++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ng;
    int acks;
    int ack_cyc;
    int n;
    logic grant_if_seen [6];

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = 32'd0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0; d_size[k] = 3'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_if_ack", if_ack[k], 0);
      check("rst_d_ack", d_ack[k], 0);
      check("rst_mem_re", mem_re[k], 0);
      check("rst_mem_we", mem_we[k], 0);
      check("rst_mem_addr", mem_addr[k], 0);
      check("rst_mem_size", mem_size[k], 0);
      check("rst_if_rdata", if_rdata[k], 0);
      check("rst_d_rdata", d_rdata[k], 0);
    end
    rst = 1'b0;
    next();

    // Fetch, MEM_LAT=1
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    @(negedge clk);
    check("t2_re", mem_re[0], 1);
    check("t2_addr", mem_addr[0], 32'h100);
    check("t2_size", mem_size[0], 3'b010);
    check("t2_ack_c0", if_ack[0], 0);
    check("t2_stall_c0", stall_if[0], 1);
    next();
    @(negedge clk);
    check("t2_ack_c1", if_ack[0], 1);
    check("t2_rdata_c1", if_rdata[0], 32'h0050_0093);
    check("t2_stall_c1", stall_if[0], 0);
    next();
    if_req[0] = 1'b0;
    @(negedge clk);
    check("t2_ack_c2", if_ack[0], 0);
    check("t2_rdata_hold", if_rdata[0], 32'h0050_0093);
    next();

    // Store then load, MEM_LAT=2
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h2000; d_wdata[1] = 32'hDEAD_BEEF; d_size[1] = 3'b010;
    @(negedge clk);
    check("t3_we", mem_we[1], 1);
    check("t3_re_low", mem_re[1], 0);
    check("t3_addr", mem_addr[1], 32'h2000);
    check("t3_wdata", mem_wdata[1], 32'hDEAD_BEEF);
    check("t3_size", mem_size[1], 3'b010);
    check("t3_ack_c0", d_ack[1], 0);
    next();
    @(negedge clk);
    check("t3_st_ack", d_ack[1], 1);
    check("t3_we_c1", mem_we[1], 0);
    next();
    d_we[1] = 1'b0;
    @(negedge clk);
    check("t3_ld_re", mem_re[1], 1);
    check("t3_ld_addr", mem_addr[1], 32'h2000);
    next();
    @(negedge clk);
    check("t3_ld_ack_c1", d_ack[1], 0);
    check("t3_ld_stall_c1", stall_d[1], 1);
    check("t3_ld_re_c1", mem_re[1], 0);
    next();
    @(negedge clk);
    check("t3_ld_ack_c2", d_ack[1], 1);
    check("t3_ld_rdata", d_rdata[1], 32'hDEAD_BEEF);
    check("t3_ld_stall_c2", stall_d[1], 0);
    next();
    d_req[1] = 1'b0;
    @(negedge clk);
    check("t3_rdata_hold", d_rdata[1], 32'hDEAD_BEEF);
    check("t3_ack_low", d_ack[1], 0);
    next();

    // Contention, MEM_LAT=2: data first, fetch right after
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h40;
    if_req[1] = 1'b1; if_addr[1] = 32'h104;
    @(negedge clk);
    check("t4_d_addr", mem_addr[1], 32'h40);
    check("t4_stall_if_c0", stall_if[1], 1);
    next();
    next();
    @(negedge clk);
    check("t4_d_ack", d_ack[1], 1);
    check("t4_if_ack_c2", if_ack[1], 0);
    check("t4_stall_if_c2", stall_if[1], 1);
    check("t4_d_rdata", d_rdata[1], ref_word(32'h40));
    next();
    d_req[1] = 1'b0;
    @(negedge clk);
    check("t4_if_re", mem_re[1], 1);
    check("t4_if_addr", mem_addr[1], 32'h104);
    check("t4_if_size", mem_size[1], 3'b010);
    next();
    next();
    @(negedge clk);
    check("t4_if_ack", if_ack[1], 1);
    check("t4_if_rdata", if_rdata[1], ref_word(32'h104));
    next();
    if_req[1] = 1'b0;
    next();

    // Continuous contention, MEM_LAT=1: grant order
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
    if_req[0] = 1'b1; if_addr[0] = 32'h200;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_re[0] && ng < 6) begin
        grant_if_seen[ng] = (mem_addr[0] == 32'h200);
        ng++;
      end
      next();
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    check("t5_ngrants", ng, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FAIRNESS_EN
      check($sformatf("t5_grant%0d", i), grant_if_seen[i], (i == 4) ? 1 : 0);
`else
      check($sformatf("t5_grant%0d", i), grant_if_seen[i], 0);
`endif
    end
    next();
    next();

    // Abandon in WAIT, MEM_LAT=3
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h300;
    @(negedge clk);
    check("t6_re", mem_re[2], 1);
    next();
    d_req[2] = 1'b0;
    acks = 0;
    ack_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (d_ack[2]) begin
        acks++;
        ack_cyc = c;
      end
      next();
    end
    check("t6_acks", acks, 1);
    check("t6_ack_cyc", ack_cyc, 3);
    check("t6_d_rdata", d_rdata[2], ref_word(32'h300));
    if_req[2] = 1'b1; if_addr[2] = 32'h108;
    @(negedge clk);
    check("t6_if_re", mem_re[2], 1);
    check("t6_if_addr", mem_addr[2], 32'h108);
    n = 0;
    do begin
      next();
      n++;
      @(negedge clk);
    end while (!if_ack[2] && n < 10);
    check("t6_if_lat", n, 3);
    check("t6_if_rdata", if_rdata[2], ref_word(32'h108));
    next();
    if_req[2] = 1'b0;
    next();

    // Reset mid-WAIT, MEM_LAT=3
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h10;
    @(negedge clk);
    check("t1_re", mem_re[2], 1);
    next();
    rst = 1'b1;
    d_req[2] = 1'b0;
    acks = 0;
    @(negedge clk);
    if (d_ack[2]) acks++;
    next();
    @(negedge clk);
    if (d_ack[2]) acks++;
    next();
    rst = 1'b0;
    @(negedge clk);
    check("t1_d_ack", d_ack[2], 0);
    check("t1_if_ack", if_ack[2], 0);
    check("t1_mem_re", mem_re[2], 0);
    check("t1_mem_we", mem_we[2], 0);
    check("t1_mem_addr", mem_addr[2], 0);
    check("t1_mem_wdata", mem_wdata[2], 0);
    check("t1_mem_size", mem_size[2], 0);
    check("t1_if_rdata", if_rdata[2], 0);
    check("t1_d_rdata", d_rdata[2], 0);
    check("t1_stall_d", stall_d[2], 0);
    for (int c = 0; c < 4; c++) begin
      next();
      @(negedge clk);
      if (d_ack[2]) acks++;
    end
    check("t1_no_ack", acks, 0);

    check("exclusive_strobes_acks", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
